// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions used by the memory-access stage:
// opcodes, load/store size codes, FSM states and lane helpers.
package riscv_pkg;

   localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
   localparam logic [6:0] OPCODE_REG_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_REG_REG = 7'b0110011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mem_state_t;

   // Unsupported size codes are folded into the misaligned path
   function automatic logic mem_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] off,
                                           input logic       is_store);
      logic mis;
      mis = 1'b1;
      case (funct3)
         F3_B:    mis = 1'b0;
         F3_H:    mis = off[0];
         F3_W:    mis = (off != 2'b00);
         F3_BU:   mis = is_store;
         F3_HU:   mis = is_store | off[0];
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] mem_byte_en(input logic [2:0] funct3,
                                              input logic [1:0] off);
      logic [3:0] be;
      be = 4'b0000;
      case (funct3)
         F3_B, F3_BU: be = 4'b0001 << off;
         F3_H, F3_HU: be = off[1] ? 4'b1100 : 4'b0011;
         F3_W:        be = 4'b1111;
         default:     be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] mem_store_data(input logic [2:0]  funct3,
                                                  input logic [31:0] rs2);
      logic [31:0] wd;
      wd = 32'h0000_0000;
      case (funct3)
         F3_B:    wd = {4{rs2[7:0]}};
         F3_H:    wd = {2{rs2[15:0]}};
         F3_W:    wd = rs2;
         default: wd = 32'h0000_0000;
      endcase
      return wd;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/half/word from a load word and sign- or
// zero-extends it according to funct3.
module mem_load_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  lane_byte_s;
   logic [15:0] lane_half_s;

   // Lane select and extension
   always_comb begin
      lane_byte_s = rdata[{addr_lo, 3'b000} +: 8];
      lane_half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      result      = 32'h0000_0000;
      case (funct3)
         F3_B:    result = {{24{lane_byte_s[7]}}, lane_byte_s};
         F3_BU:   result = {24'h00_0000, lane_byte_s};
         F3_H:    result = {{16{lane_half_s[15]}}, lane_half_s};
         F3_HU:   result = {16'h0000, lane_half_s};
         F3_W:    result = rdata;
         default: result = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte/half/word loads and stores over a
// req/gnt/rvalid data port, ALU pass-through, registered writeback output.
module mem_stage
   import riscv_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         em_valid,
   output logic         em_ready,
   input  logic [N-1:0] em_alu_result,
   input  logic [N-1:0] em_rs2_data,
   input  logic [6:0]   em_opcode,
   input  logic [2:0]   em_funct3,
   input  logic [4:0]   em_rd,
   output logic         dmem_req,
   output logic         dmem_we,
   output logic [N-1:0] dmem_addr,
   output logic [3:0]   dmem_be,
   output logic [N-1:0] dmem_wdata,
   input  logic         dmem_gnt,
   input  logic         dmem_rvalid,
   input  logic [N-1:0] dmem_rdata,
   output logic         mw_valid,
   input  logic         mw_ready,
   output logic [N-1:0] mw_result,
   output logic [4:0]   mw_rd,
   output logic         mw_reg_write,
   output logic         mw_misalign
);

   mem_state_t state_q, state_d;

   logic         mw_valid_q, mw_valid_d;
   logic [N-1:0] mw_result_q, mw_result_d;
   logic [4:0]   mw_rd_q, mw_rd_d;
   logic         mw_reg_write_q, mw_reg_write_d;
   logic         mw_misalign_q, mw_misalign_d;
   logic         dmem_req_q, dmem_req_d;
   logic         dmem_we_q, dmem_we_d;
   logic [N-1:0] dmem_addr_q, dmem_addr_d;
   logic [3:0]   dmem_be_q, dmem_be_d;
   logic [N-1:0] dmem_wdata_q, dmem_wdata_d;
   logic [2:0]   funct3_q, funct3_d;
   logic [1:0]   addr_lo_q, addr_lo_d;
   logic [4:0]   rd_q, rd_d;

   logic         is_load_s;
   logic         is_store_s;
   logic         misalign_s;
   logic         alu_write_s;
   logic         accept_s;
   logic [N-1:0] load_value_s;

   assign is_load_s   = (em_opcode == OPCODE_LOAD);
   assign is_store_s  = (em_opcode == OPCODE_STORE);
   assign misalign_s  = mem_misaligned(em_funct3, em_alu_result[1:0], is_store_s);
   assign alu_write_s = ((em_opcode == OPCODE_REG_REG) || (em_opcode == OPCODE_REG_IMM))
                        && (em_rd != 5'd0);

   // The output slot must be free, or draining this cycle, before accepting
   assign em_ready = (state_q == IDLE) && (!mw_valid_q || mw_ready);
   assign accept_s = em_valid && em_ready;

   mem_load_align u_load_align (
      .rdata   (dmem_rdata),
      .addr_lo (addr_lo_q),
      .funct3  (funct3_q),
      .result  (load_value_s)
   );

   // Next-state, request and writeback-result logic
   always_comb begin
      state_d        = state_q;
      mw_valid_d     = mw_valid_q && !mw_ready;
      mw_result_d    = mw_result_q;
      mw_rd_d        = mw_rd_q;
      mw_reg_write_d = mw_reg_write_q;
      mw_misalign_d  = mw_misalign_q;
      dmem_req_d     = dmem_req_q;
      dmem_we_d      = dmem_we_q;
      dmem_addr_d    = dmem_addr_q;
      dmem_be_d      = dmem_be_q;
      dmem_wdata_d   = dmem_wdata_q;
      funct3_d       = funct3_q;
      addr_lo_d      = addr_lo_q;
      rd_d           = rd_q;

      if (accept_s) begin
         if (is_load_s || is_store_s) begin
            if (misalign_s) begin
               mw_valid_d     = 1'b1;
               mw_result_d    = {N{1'b0}};
               mw_rd_d        = em_rd;
               mw_reg_write_d = 1'b0;
               mw_misalign_d  = 1'b1;
            end else begin
               state_d      = REQ;
               dmem_req_d   = 1'b1;
               dmem_we_d    = is_store_s;
               dmem_addr_d  = {em_alu_result[N-1:2], 2'b00};
               dmem_be_d    = mem_byte_en(em_funct3, em_alu_result[1:0]);
               dmem_wdata_d = mem_store_data(em_funct3, em_rs2_data);
               funct3_d     = em_funct3;
               addr_lo_d    = em_alu_result[1:0];
               rd_d         = em_rd;
            end
         end else begin
            mw_valid_d     = 1'b1;
            mw_result_d    = em_alu_result;
            mw_rd_d        = em_rd;
            mw_reg_write_d = alu_write_s;
            mw_misalign_d  = 1'b0;
         end
      end else begin
         case (state_q)
            IDLE: state_d = IDLE;
            REQ: begin
               if (dmem_gnt) begin
                  dmem_req_d = 1'b0;
                  if (dmem_we_q) begin
                     state_d        = IDLE;
                     mw_valid_d     = 1'b1;
                     mw_result_d    = {N{1'b0}};
                     mw_rd_d        = rd_q;
                     mw_reg_write_d = 1'b0;
                     mw_misalign_d  = 1'b0;
                  end else begin
                     state_d = WAIT;
                  end
               end else begin
                  state_d = REQ;
               end
            end
            WAIT: begin
               if (dmem_rvalid) begin
                  state_d        = IDLE;
                  mw_valid_d     = 1'b1;
                  mw_result_d    = load_value_s;
                  mw_rd_d        = rd_q;
                  mw_reg_write_d = (rd_q != 5'd0);
                  mw_misalign_d  = 1'b0;
               end else begin
                  state_d = WAIT;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Stage registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         mw_valid_q     <= 1'b0;
         mw_result_q    <= {N{1'b0}};
         mw_rd_q        <= 5'd0;
         mw_reg_write_q <= 1'b0;
         mw_misalign_q  <= 1'b0;
         dmem_req_q     <= 1'b0;
         dmem_we_q      <= 1'b0;
         dmem_addr_q    <= {N{1'b0}};
         dmem_be_q      <= 4'b0000;
         dmem_wdata_q   <= {N{1'b0}};
         funct3_q       <= 3'b000;
         addr_lo_q      <= 2'b00;
         rd_q           <= 5'd0;
      end else begin
         state_q        <= state_d;
         mw_valid_q     <= mw_valid_d;
         mw_result_q    <= mw_result_d;
         mw_rd_q        <= mw_rd_d;
         mw_reg_write_q <= mw_reg_write_d;
         mw_misalign_q  <= mw_misalign_d;
         dmem_req_q     <= dmem_req_d;
         dmem_we_q      <= dmem_we_d;
         dmem_addr_q    <= dmem_addr_d;
         dmem_be_q      <= dmem_be_d;
         dmem_wdata_q   <= dmem_wdata_d;
         funct3_q       <= funct3_d;
         addr_lo_q      <= addr_lo_d;
         rd_q           <= rd_d;
      end
   end

   assign mw_valid     = mw_valid_q;
   assign mw_result    = mw_result_q;
   assign mw_rd        = mw_rd_q;
   assign mw_reg_write = mw_reg_write_q;
   assign mw_misalign  = mw_misalign_q;
   assign dmem_req     = dmem_req_q;
   assign dmem_we      = dmem_we_q;
   assign dmem_addr    = dmem_addr_q;
   assign dmem_be      = dmem_be_q;
   assign dmem_wdata   = dmem_wdata_q;

endmodule
